// File: rtl/uart_txrx_if.sv
// Handshake bundle between the memory-mapped I/O block and the UART.
// master: I/O block side; slave: UART side.
interface uart_txrx_if;
  logic [7:0] tx_data;
  logic       tx_go;
  logic       tx_bsy;
  logic       rx_go;
  logic [7:0] rx_data;
  logic       rx_data_ready;

  modport master (
    output tx_data,
    output tx_go,
    output rx_go,
    input  tx_bsy,
    input  rx_data,
    input  rx_data_ready
  );

  modport slave (
    input  tx_data,
    input  tx_go,
    input  rx_go,
    output tx_bsy,
    output rx_data,
    output rx_data_ready
  );
endinterface

// File: rtl/uart_txrx.sv
// 8N1 UART transmitter/receiver pair, LSB first, idle-high line.
// Ports: clk, rst (sync, active high), bus (handshakes), tx pin, rx pin.
module uart_txrx #(
  parameter int ClockFrequencyHz = 20_250_000,
  parameter int BaudRate         = 9600
) (
  input  logic       clk,
  input  logic       rst,
  uart_txrx_if.slave bus,
  output logic       tx,
  input  logic       rx
);
  localparam int BitTime = ClockFrequencyHz / BaudRate;
  localparam int CW = (BitTime > 2) ? $clog2(BitTime) : 1;
  localparam logic [CW-1:0] BtLast = CW'(BitTime - 1);
  localparam logic [CW-1:0] HalfLast = CW'(BitTime / 2 - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP, TX_DONE
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_READY
  } rx_state_t;

  tx_state_t     tx_st;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_sh;
  logic          tx_tick;

  assign tx_tick = (tx_cnt == BtLast);

  // Idle follows tx_go so a request is never seen as "not busy".
  assign bus.tx_bsy = (tx_st == TX_IDLE) ? bus.tx_go
                                         : (tx_st != TX_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_st  <= TX_IDLE;
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
      tx     <= 1'b1;
    end else begin
      unique case (tx_st)
        TX_IDLE: begin
          tx     <= 1'b1;
          tx_cnt <= '0;
          tx_idx <= '0;
          if (bus.tx_go) begin
            tx_sh <= bus.tx_data;
            tx    <= 1'b0;
            tx_st <= TX_START;
          end
        end
        TX_START: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx     <= tx_sh[0];
            tx_st  <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_sh  <= {1'b1, tx_sh[7:1]};
            tx_idx <= tx_idx + 1'b1;
            if (tx_idx == 3'd7) begin
              tx    <= 1'b1;
              tx_st <= TX_STOP;
            end else begin
              tx <= tx_sh[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_tick) begin
            tx_cnt <= '0;
            tx_st  <= TX_DONE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DONE: begin
          tx <= 1'b1;
          if (!bus.tx_go) tx_st <= TX_IDLE;
        end
        default: tx_st <= TX_IDLE;
      endcase
    end
  end

  logic          rx_m;
  logic          rx_s;
  rx_state_t     rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_sh;
  logic          rx_rdy;

  assign bus.rx_data       = rx_sh;
  assign bus.rx_data_ready = rx_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_st  <= RX_IDLE;
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh  <= '0;
      rx_rdy <= 1'b0;
    end else begin
      unique case (rx_st)
        RX_IDLE: begin
          rx_cnt <= '0;
          rx_idx <= '0;
          if (bus.rx_go && !rx_s) rx_st <= RX_START;
        end
        RX_START: begin
          // Half a bit in: a high line means the edge was noise.
          if (rx_cnt == HalfLast) begin
            rx_cnt <= '0;
            rx_st  <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BtLast) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_idx <= rx_idx + 1'b1;
            if (rx_idx == 3'd7) rx_st <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BtLast) begin
            rx_cnt <= '0;
            rx_rdy <= 1'b1;
            rx_st  <= RX_READY;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_READY: begin
          if (!bus.rx_go) begin
            rx_rdy <= 1'b0;
            rx_st  <= RX_IDLE;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_txrx.sv
// Directed bench for uart_txrx at BitTime = 10.
// Table of TX/RX vectors plus hand-written corner sequences.
module tb_uart_txrx;
  logic clk;
  logic rst;
  logic tx;
  logic rx;
  logic rx_drv;
  logic loop;

  int total;
  int bad;

  uart_txrx_if bus ();

  assign rx = loop ? tx : rx_drv;

  uart_txrx #(
    .ClockFrequencyHz(1_000_000),
    .BaudRate(100_000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .tx(tx),
    .rx(rx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         is_rx;
    logic [7:0] data;
    logic [9:0] frame;
    logic [7:0] exp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tx_frame(input logic [7:0] b, input logic [9:0] frame);
    @(negedge clk);
    bus.tx_data = b;
    bus.tx_go = 1'b1;
    #1;
    chk("tx_bsy_same_cycle", 32'(bus.tx_bsy), 32'd1);
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("tx_lvl_%0d", k), 32'(tx), 32'(frame[k / 10]));
      chk($sformatf("tx_bsy_%0d", k), 32'(bus.tx_bsy), 32'd1);
      if (k == 30) bus.tx_data = ~b;
    end
    @(posedge clk);
    #1;
    chk("tx_bsy_done", 32'(bus.tx_bsy), 32'd0);
    chk("tx_done_line", 32'(tx), 32'd1);
    @(negedge clk);
    bus.tx_go = 1'b0;
    @(posedge clk);
    #1;
    chk("tx_idle_bsy", 32'(bus.tx_bsy), 32'd0);
    chk("tx_idle_line", 32'(tx), 32'd1);
  endtask

  task automatic drive_frame(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_drv = f[i];
      repeat (9) @(negedge clk);
    end
  endtask

  task automatic wait_rdy(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim && !ok; i++) begin
      @(posedge clk);
      #1;
      if (bus.rx_data_ready) ok = 1'b1;
    end
  endtask

  task automatic rx_ack();
    @(negedge clk);
    bus.rx_go = 1'b0;
    @(posedge clk);
    #1;
    chk("rx_rdy_cleared", 32'(bus.rx_data_ready), 32'd0);
    @(negedge clk);
    bus.rx_go = 1'b1;
  endtask

  task automatic rx_byte(input logic [7:0] b, input logic [7:0] exp);
    bit ok;
    @(negedge clk);
    bus.rx_go = 1'b1;
    drive_frame(b);
    wait_rdy(40, ok);
    chk("rx_rdy_timeout", 32'(ok), 32'd1);
    chk("rx_data", 32'(bus.rx_data), 32'(exp));
    repeat (5) @(posedge clk);
    #1;
    chk("rx_rdy_held", 32'(bus.rx_data_ready), 32'd1);
    chk("rx_data_held", 32'(bus.rx_data), 32'(exp));
    rx_ack();
  endtask

  task automatic loop_byte(input logic [7:0] b);
    bit ok;
    bit bdone;
    loop = 1'b1;
    @(negedge clk);
    bus.rx_go = 1'b1;
    bus.tx_data = b;
    bus.tx_go = 1'b1;
    wait_rdy(150, ok);
    chk("lb_rdy_timeout", 32'(ok), 32'd1);
    chk("lb_data", 32'(bus.rx_data), 32'(b));
    bdone = 1'b0;
    for (int i = 0; i < 50 && !bdone; i++) begin
      if (!bus.tx_bsy) bdone = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    chk("lb_tx_done", 32'(bdone), 32'd1);
    @(negedge clk);
    bus.tx_go = 1'b0;
    rx_ack();
    repeat (3) @(posedge clk);
    loop = 1'b0;
  endtask

  initial begin
    vec_t vecs[4];
    bit   ok;
    bit   seen;

    total = 0;
    bad = 0;
    rst = 1'b1;
    loop = 1'b0;
    rx_drv = 1'b1;
    bus.tx_data = 8'h00;
    bus.tx_go = 1'b0;
    bus.rx_go = 1'b0;

    vecs[0] = '{1'b0, 8'hA5, 10'b1101001010, 8'h00};
    vecs[1] = '{1'b0, 8'h3C, 10'b1001111000, 8'h00};
    vecs[2] = '{1'b1, 8'h5A, 10'b0000000000, 8'h5A};
    vecs[3] = '{1'b1, 8'hFF, 10'b0000000000, 8'hFF};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_tx_bsy", 32'(bus.tx_bsy), 32'd0);
    chk("rst_rx_rdy", 32'(bus.rx_data_ready), 32'd0);
    chk("rst_rx_data", 32'(bus.rx_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);

    foreach (vecs[i]) begin
      if (vecs[i].is_rx) rx_byte(vecs[i].data, vecs[i].exp);
      else tx_frame(vecs[i].data, vecs[i].frame);
    end

    // Three-cycle glitch must not start a frame.
    @(negedge clk);
    bus.rx_go = 1'b1;
    rx_drv = 1'b0;
    repeat (3) @(negedge clk);
    rx_drv = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.rx_data_ready) seen = 1'b1;
    end
    chk("glitch_no_rdy", 32'(seen), 32'd0);
    rx_byte(8'h01, 8'h01);

    loop_byte(8'h00);
    loop_byte(8'h80);
    loop_byte(8'hFF);

    // Reset during data bit 4.
    @(negedge clk);
    bus.tx_data = 8'hC3;
    bus.tx_go = 1'b1;
    repeat (55) @(negedge clk);
    rst = 1'b1;
    bus.tx_go = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_bsy", 32'(bus.tx_bsy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    tx_frame(8'h96, 10'b1100101100);

    // Receiver still works after the reset.
    rx_byte(8'hA3, 8'hA3);
    wait_rdy(2, ok);
    chk("final_no_rdy", 32'(ok), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
